freq_report_framer: RTL and testbench

- Sits between the two frequency-meter channels and a single-byte UART transmitter.
- Latches each channel's 64-bit frequency result when its done pulse arrives.
- On every report tick (SEND_HZ per second), snapshots both channels and emits two framed, checksummed binary packets (channel 1, then channel 2) one byte at a time, over a valid/busy handshake.

---
 rtl/freq_report_framer.sv | 171 +++++++++++++++++
 tb/tb_freq_report_framer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_report_framer.sv
// Latches two 64-bit frequency results and, on each report tick, streams two
// 13-byte checksummed frames (channel 1 then channel 2) to a byte transmitter.
module freq_report_framer #(
  parameter int         CLK_FS  = 50000000,
  parameter int         SEND_HZ = 10,
  parameter logic [7:0] HDR0    = 8'hAA,
  parameter logic [7:0] HDR1    = 8'h55,
  parameter int         BUSY_TO = 15
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [63:0] freq_data_1,
  input  logic        freq_done_1,
  input  logic [63:0] freq_data_2,
  input  logic        freq_done_2,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  output logic        frame_active
);

  localparam int PERIOD = CLK_FS / SEND_HZ;
  localparam int TW     = $clog2(PERIOD);
  localparam int WW     = $clog2(BUSY_TO + 1);
  localparam logic [TW-1:0] T_LAST = TW'(PERIOD - 1);
  localparam logic [WW-1:0] W_LAST = WW'(BUSY_TO - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_HI, WAIT_LO, NEXT} state_t;
  state_t state, state_nx;

  logic [TW-1:0] tcnt;
  logic          tick;
  logic [63:0]   cap_1, cap_2, snap_1, snap_2;
  logic          fresh_1, fresh_2, ovr;
  logic [7:0]    status_1, status_2;
  logic [3:0]    idx;
  logic          ch2;
  logic [WW-1:0] wcnt;
  logic          snap_take;
  logic          tx_en_nx;
  logic [7:0]    cur_byte;

  // Byte idx of a frame; the checksum covers ID, STATUS and the eight data bytes.
  function automatic logic [7:0] frame_byte(input logic [3:0] i, input logic [7:0] id,
                                            input logic [7:0] st, input logic [63:0] d);
    logic [7:0] cks;
    logic [7:0] b;
    cks = id + st;
    for (int k = 0; k < 8; k++) cks = cks + d[8*k +: 8];
    case (i)
      4'd0:    b = HDR0;
      4'd1:    b = HDR1;
      4'd2:    b = id;
      4'd3:    b = st;
      4'd12:   b = cks;
      default: b = (i <= 4'd11) ? 8'(d >> {4'd11 - i, 3'b000}) : 8'h00;
    endcase
    return b;
  endfunction

  assign tick = (tcnt == T_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) tcnt <= '0;
    else if (tick)  tcnt <= '0;
    else            tcnt <= tcnt + 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    tx_en_nx  = 1'b0;
    snap_take = 1'b0;
    cur_byte  = ch2 ? frame_byte(idx, 8'h02, status_2, snap_2)
                    : frame_byte(idx, 8'h01, status_1, snap_1);
    case (state)
      IDLE: if (tick) begin
        snap_take = 1'b1;
        state_nx  = LOAD;
      end
      LOAD:  state_nx = START;
      START: if (!tx_busy) begin
        tx_en_nx = 1'b1;
        state_nx = WAIT_HI;
      end
      // A transmitter that never reports busy is assumed to have taken the byte.
      WAIT_HI: begin
        if (tx_busy)              state_nx = WAIT_LO;
        else if (wcnt == W_LAST)  state_nx = NEXT;
      end
      WAIT_LO: if (!tx_busy) state_nx = NEXT;
      NEXT:    state_nx = (idx == 4'd12 && ch2) ? IDLE : LOAD;
      default: state_nx = IDLE;
    endcase
  end

  // A done pulse coincident with a snapshot wins: fresh stays set for the next report.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cap_1    <= '0;
      cap_2    <= '0;
      fresh_1  <= 1'b0;
      fresh_2  <= 1'b0;
      ovr      <= 1'b0;
      snap_1   <= '0;
      snap_2   <= '0;
      status_1 <= '0;
      status_2 <= '0;
    end else begin
      if (freq_done_1) begin
        cap_1   <= freq_data_1;
        fresh_1 <= 1'b1;
      end else if (snap_take) begin
        fresh_1 <= 1'b0;
      end
      if (freq_done_2) begin
        cap_2   <= freq_data_2;
        fresh_2 <= 1'b1;
      end else if (snap_take) begin
        fresh_2 <= 1'b0;
      end
      if (snap_take)                  ovr <= 1'b0;
      else if (tick && state != IDLE) ovr <= 1'b1;
      if (snap_take) begin
        snap_1   <= cap_1;
        snap_2   <= cap_2;
        status_1 <= {6'b0, ovr, fresh_1};
        status_2 <= {6'b0, ovr, fresh_2};
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idx          <= '0;
      ch2          <= 1'b0;
      wcnt         <= '0;
      tx_data      <= '0;
      tx_en        <= 1'b0;
      frame_active <= 1'b0;
    end else begin
      tx_en <= tx_en_nx;
      case (state)
        IDLE: if (tick) begin
          idx          <= '0;
          ch2          <= 1'b0;
          frame_active <= 1'b1;
        end
        LOAD:    tx_data <= cur_byte;
        START:   wcnt <= '0;
        WAIT_HI: if (!tx_busy && wcnt != W_LAST) wcnt <= wcnt + 1'b1;
        NEXT: begin
          if (idx != 4'd12) begin
            idx <= idx + 4'd1;
          end else if (!ch2) begin
            ch2 <= 1'b1;
            idx <= '0;
          end else begin
            frame_active <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_report_framer.sv
// Bench for freq_report_framer: table of single-report vectors, hand sequences for
// overrun / coincident capture / busy timeout / reset, and a randomized phase.
module tb_freq_report_framer;

  localparam int PERIOD = 500;

  logic        clk;
  logic        rst_n;
  logic [63:0] freq_data_1, freq_data_2;
  logic        freq_done_1, freq_done_2;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        frame_active;

  freq_report_framer #(
    .CLK_FS (1000),
    .SEND_HZ(2),
    .HDR0   (8'hAA),
    .HDR1   (8'h55),
    .BUSY_TO(15)
  ) dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .freq_data_1 (freq_data_1),
    .freq_done_1 (freq_done_1),
    .freq_data_2 (freq_data_2),
    .freq_done_2 (freq_done_2),
    .tx_busy     (tx_busy),
    .tx_data     (tx_data),
    .tx_en       (tx_en),
    .frame_active(frame_active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model state: latched values, report queue of expected bytes.
  int          cyc;
  logic [63:0] m_cap1, m_cap2;
  bit          m_f1, m_f2, m_ovr;
  logic [7:0]  exp_q[$];
  logic [7:0]  rx[26], last_rpt[26];
  int          ten[26], last_ten[26];
  int          rx_n, rpt_count, last_en;
  bit          prev_en;

  int busy_len  = 10;
  bit rand_busy = 0;

  function automatic void push_frame(input logic [7:0] id, input logic [7:0] st,
                                     input logic [63:0] d);
    int s;
    s = id + st;
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    exp_q.push_back(id);
    exp_q.push_back(st);
    for (int k = 7; k >= 0; k--) begin
      exp_q.push_back(d[8*k +: 8]);
      s += d[8*k +: 8];
    end
    exp_q.push_back(8'(s % 256));
  endfunction

  initial begin
    rpt_count = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cyc = 0; m_cap1 = 0; m_cap2 = 0; m_f1 = 0; m_f2 = 0; m_ovr = 0;
        exp_q.delete(); rx_n = 0; prev_en = 0; last_en = -100;
      end else begin
        cyc++;
        if (cyc % PERIOD == 0) begin
          if (exp_q.size() == 0) begin
            push_frame(8'h01, {6'b0, m_ovr, m_f1}, m_cap1);
            push_frame(8'h02, {6'b0, m_ovr, m_f2}, m_cap2);
            m_f1 = 0; m_f2 = 0; m_ovr = 0;
          end else begin
            m_ovr = 1;
          end
        end
        if (freq_done_1) begin m_cap1 = freq_data_1; m_f1 = 1; end
        if (freq_done_2) begin m_cap2 = freq_data_2; m_f2 = 1; end
        #1;
        if (tx_en) begin
          check("tx_protocol", {prev_en, tx_busy, (cyc - last_en >= 4)}, 3'b001);
          last_en = cyc;
          check("tx_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("tx_byte", tx_data, exp_q.pop_front());
          rx[rx_n] = tx_data;
          ten[rx_n] = cyc;
          rx_n++;
          if (rx_n == 26) begin
            last_rpt = rx;
            last_ten = ten;
            rx_n = 0;
            rpt_count++;
          end
        end
        prev_en = tx_en;
      end
    end
  end

  // Transmitter stand-in: busy from the cycle after tx_en for L cycles (0 = never busy).
  initial begin
    int L;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_en === 1'b1) begin
        L = rand_busy ? int'($urandom_range(0, 10)) : busy_len;
        if (L > 0) begin
          tx_busy = 1'b1;
          repeat (L) @(negedge clk);
          tx_busy = 1'b0;
        end
      end
    end
  end

  task automatic wait_report(input int bound);
    int start, n;
    start = rpt_count;
    n = 0;
    while (rpt_count == start && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("report_arrived", rpt_count != start, 1);
  endtask

  task automatic pulse(input bit c2, input logic [63:0] d);
    @(negedge clk);
    if (c2) begin freq_data_2 = d; freq_done_2 = 1'b1; end
    else    begin freq_data_1 = d; freq_done_1 = 1'b1; end
    @(negedge clk);
    freq_done_1 = 1'b0;
    freq_done_2 = 1'b0;
  endtask

  typedef struct {
    int          busy;
    bit          set1;
    logic [63:0] d1;
    bit          set2;
    logic [63:0] d2;
    logic [7:0]  st1, ck1, st2, ck2;
  } vec_t;
  vec_t vt[4];

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vt[0] = '{10, 1'b1, 64'h0000_0000_0098_9680, 1'b0, 64'h0, 8'h01, 8'hB0, 8'h00, 8'h02};
    vt[1] = '{10, 1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 8'hAF, 8'h00, 8'h02};
    vt[2] = '{3, 1'b0, 64'h0, 1'b1, 64'h0102_0304_0506_0708, 8'h00, 8'hAF, 8'h01, 8'h27};
    vt[3] = '{0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0, 8'h01, 8'hFA, 8'h01, 8'h03};

    rst_n = 1'b0;
    freq_data_1 = '0; freq_data_2 = '0;
    freq_done_1 = 1'b0; freq_done_2 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_en", tx_en, 0);
    check("rst_frame_active", frame_active, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      busy_len = vt[i].busy;
      if (vt[i].set1) pulse(1'b0, vt[i].d1);
      if (vt[i].set2) pulse(1'b1, vt[i].d2);
      wait_report(2000);
      check($sformatf("v%0d_status1", i), last_rpt[3], vt[i].st1);
      check($sformatf("v%0d_cks1", i), last_rpt[12], vt[i].ck1);
      check($sformatf("v%0d_status2", i), last_rpt[16], vt[i].st2);
      check($sformatf("v%0d_cks2", i), last_rpt[25], vt[i].ck2);
    end

    // Overrun: a slow transmitter makes later ticks land mid-report.
    busy_len = 200;
    wait_report(8000);
    check("ovr_slow_status1", last_rpt[3], 8'h00);
    busy_len = 10;
    wait_report(2000);
    check("ovr_status1", last_rpt[3], 8'h02);
    check("ovr_status2", last_rpt[16], 8'h02);
    wait_report(2000);
    check("ovr_cleared_status1", last_rpt[3], 8'h00);
    check("ovr_cleared_status2", last_rpt[16], 8'h00);

    // Done pulse on the very tick edge: old value goes out, new one waits.
    pulse(1'b0, 64'h3);
    n = 0;
    while (cyc % PERIOD != PERIOD - 1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("pre_tick_align", cyc % PERIOD, PERIOD - 1);
    freq_data_1 = 64'h5;
    freq_done_1 = 1'b1;
    @(negedge clk);
    freq_done_1 = 1'b0;
    wait_report(2000);
    check("coinc_old_d0", last_rpt[11], 8'h03);
    check("coinc_old_status", last_rpt[3], 8'h01);
    wait_report(2000);
    check("coinc_new_d0", last_rpt[11], 8'h05);
    check("coinc_new_status", last_rpt[3], 8'h01);

    // Transmitter that never goes busy: each byte times out.
    busy_len = 0;
    wait_report(2000);
    for (int k = 0; k < 25; k++)
      check($sformatf("timeout_gap%0d", k), last_ten[k+1] - last_ten[k], 18);
    repeat (20) @(negedge clk);
    check("timeout_idle", frame_active, 0);

    // Randomized captures with random transmitter latency.
    rand_busy = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      freq_data_1 = {$urandom, $urandom};
      freq_data_2 = {$urandom, $urandom};
      freq_done_1 = ($urandom_range(0, 39) == 0);
      freq_done_2 = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    freq_done_1 = 1'b0;
    freq_done_2 = 1'b0;
    rand_busy = 0;
    busy_len = 10;

    // Reset in the middle of a frame.
    n = 0;
    while (rx_n != 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reach_byte5", rx_n, 5);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx_data", tx_data, 0);
    check("midrst_tx_en", tx_en, 0);
    check("midrst_frame_active", frame_active, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (cyc != PERIOD - 1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("post_rst_fa_before_tick", frame_active, 0);
    @(negedge clk);
    check("post_rst_fa_after_tick", frame_active, 1);
    wait_report(2000);
    check("post_rst_first_tx_en", last_ten[0], PERIOD + 2);
    check("post_rst_status1", last_rpt[3], 8'h00);
    check("post_rst_d0", last_rpt[11], 8'h00);
    check("post_rst_cks1", last_rpt[12], 8'h01);
    check("post_rst_cks2", last_rpt[25], 8'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
